// File: rtl/memory_layer_node_alloc_arb.sv
// ---------------------------------------------------------------------------
// memory_layer_node_alloc_arb
//
// Shared per-class node counter bank for the GAM memory layer. NUM_REQ
// learning lanes compete for it through a round-robin arbiter. A granted
// request reads the counter of its class and increments it, then returns
// the allocated node index. A class that has reached NODE_MAX is refused
// instead (ack_deny). A per-class clear and a combinational count query for
// the recall path are also provided.
//
// Ports:
//   clk            rising-edge clock
//   rst_n          asynchronous active-low reset
//   req            level request per requester, held until its ack
//   req_class      class per requester, slice [i*CLASS_W +: CLASS_W]
//   ack            one-hot, one-cycle completion pulse
//   ack_node_idx   allocated node index, valid with ack
//   ack_deny       class full and nothing allocated, valid with ack
//   clear_en       one-cycle pulse that zeroes counter clear_class
//   clear_class    class to clear
//   query_class    class to read
//   query_count    combinational count of query_class
//   busy           transaction in progress (FSM not idle)
//   deny_count     saturating count of denied grants
//                  (present only with GAM_NODE_DENY_CNT_EN defined)
//
// Optional feature macro: GAM_NODE_DENY_CNT_EN
// ---------------------------------------------------------------------------
module memory_layer_node_alloc_arb #(
    parameter int NUM_REQ   = 4,
    parameter int NUM_CLASS = 8,
    parameter int CLASS_W   = 3,
    parameter int NODE_W    = 8,
    parameter int NODE_MAX  = 255
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [NUM_REQ-1:0]         req,
    input  logic [NUM_REQ*CLASS_W-1:0] req_class,
    output logic [NUM_REQ-1:0]         ack,
    output logic [NODE_W-1:0]          ack_node_idx,
    output logic                       ack_deny,
    input  logic                       clear_en,
    input  logic [CLASS_W-1:0]         clear_class,
    input  logic [CLASS_W-1:0]         query_class,
    output logic [NODE_W-1:0]          query_count,
    output logic                       busy
`ifdef GAM_NODE_DENY_CNT_EN
    ,
    output logic [15:0]                deny_count
`endif
);

    localparam int ID_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam logic [NODE_W-1:0] NODE_MAX_V = NODE_W'(NODE_MAX);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_UPDATE = 2'd1;
    localparam logic [1:0] ST_RESP   = 2'd2;

    logic [1:0]         state_r;
    logic [ID_W-1:0]    rr_r;
    logic [ID_W-1:0]    win_r;
    logic [CLASS_W-1:0] cls_r;
    logic [NODE_W-1:0]  idx_r;
    logic               deny_r;
    logic [NUM_REQ-1:0] ack_r;
    logic               clear_pend_r;
    logic [CLASS_W-1:0] clear_cls_r;
    logic [NODE_W-1:0]  count_r [NUM_CLASS];

    logic [ID_W-1:0]    win_s;
    logic [ID_W-1:0]    cand_s;
    logic               found_s;
    logic [ID_W-1:0]    rr_next_s;

    // Round-robin pick: first active requester at or after the rr pointer.
    always_comb begin
        win_s   = rr_r;
        cand_s  = rr_r;
        found_s = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            cand_s  = ID_W'((int'(rr_r) + k) % NUM_REQ);
            win_s   = (!found_s && req[cand_s]) ? cand_s : win_s;
            found_s = found_s | req[cand_s];
        end
    end

    // Pointer moves one past the requester just served so it goes last next time.
    always_comb begin
        rr_next_s = (win_r == ID_W'(NUM_REQ - 1)) ? '0 : (win_r + ID_W'(1));
    end

    // Arbitration FSM, counter bank, deferred clear and response registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r      <= ST_IDLE;
            rr_r         <= '0;
            win_r        <= '0;
            cls_r        <= '0;
            idx_r        <= '0;
            deny_r       <= 1'b0;
            ack_r        <= '0;
            clear_pend_r <= 1'b0;
            clear_cls_r  <= '0;
            for (int i = 0; i < NUM_CLASS; i++) begin
                count_r[i] <= '0;
            end
        end else begin
            case (state_r)
                ST_IDLE: begin
                    // A clear takes the whole idle cycle; a fresh pulse
                    // supersedes an older pending class (last one wins).
                    if (clear_en) begin
                        count_r[clear_class] <= '0;
                        clear_pend_r         <= 1'b0;
                    end else if (clear_pend_r) begin
                        count_r[clear_cls_r] <= '0;
                        clear_pend_r         <= 1'b0;
                    end else if (|req) begin
                        win_r   <= win_s;
                        cls_r   <= req_class[int'(win_s)*CLASS_W +: CLASS_W];
                        state_r <= ST_UPDATE;
                    end else begin
                        state_r <= ST_IDLE;
                    end
                end
                ST_UPDATE: begin
                    // Saturate instead of wrapping: a full class is refused.
                    if (count_r[cls_r] < NODE_MAX_V) begin
                        idx_r          <= count_r[cls_r];
                        count_r[cls_r] <= count_r[cls_r] + NODE_W'(1);
                        deny_r         <= 1'b0;
                    end else begin
                        idx_r          <= NODE_MAX_V;
                        deny_r         <= 1'b1;
                    end
                    ack_r   <= NUM_REQ'(1) << win_r;
                    state_r <= ST_RESP;
                    if (clear_en) begin
                        clear_pend_r <= 1'b1;
                        clear_cls_r  <= clear_class;
                    end else begin
                        clear_pend_r <= clear_pend_r;
                    end
                end
                ST_RESP: begin
                    ack_r   <= '0;
                    idx_r   <= '0;
                    deny_r  <= 1'b0;
                    rr_r    <= rr_next_s;
                    state_r <= ST_IDLE;
                    if (clear_en) begin
                        clear_pend_r <= 1'b1;
                        clear_cls_r  <= clear_class;
                    end else begin
                        clear_pend_r <= clear_pend_r;
                    end
                end
                default: begin
                    ack_r   <= '0;
                    idx_r   <= '0;
                    deny_r  <= 1'b0;
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

`ifdef GAM_NODE_DENY_CNT_EN
    logic [15:0] deny_cnt_r;

    // Saturating tally of denied grants; only rst_n clears it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            deny_cnt_r <= 16'd0;
        end else if ((state_r == ST_RESP) && deny_r && (deny_cnt_r != 16'hFFFF)) begin
            deny_cnt_r <= deny_cnt_r + 16'd1;
        end else begin
            deny_cnt_r <= deny_cnt_r;
        end
    end

    assign deny_count = deny_cnt_r;
`endif

    assign ack          = ack_r;
    assign ack_node_idx = idx_r;
    assign ack_deny     = deny_r;
    assign busy         = (state_r != ST_IDLE);
    assign query_count  = count_r[query_class];

endmodule

// File: tb/tb_memory_layer_node_alloc_arb.sv
// ---------------------------------------------------------------------------
// Testbench for memory_layer_node_alloc_arb. Two instances share clock and
// reset: u_main with default parameters and u_sat with NODE_MAX=3 for the
// saturation/deny boundary. Table-driven vectors plus hand-written
// sequences for round-robin, deferred clear and mid-transaction reset.
// ---------------------------------------------------------------------------
module tb_memory_layer_node_alloc_arb;

    logic        clk;
    logic        rst_n;

    logic [3:0]  req_m,  req_s;
    logic [11:0] cls_m,  cls_s;
    logic [3:0]  ack_m,  ack_s;
    logic [7:0]  idx_m,  idx_s;
    logic        deny_m, deny_s;
    logic        clr_en_m, clr_en_s;
    logic [2:0]  clr_cls_m, clr_cls_s;
    logic [2:0]  q_cls_m, q_cls_s;
    logic [7:0]  q_cnt_m, q_cnt_s;
    logic        busy_m, busy_s;
`ifdef GAM_NODE_DENY_CNT_EN
    logic [15:0] dcnt_m, dcnt_s;
`endif

    int n_pass;
    int n_total;

    memory_layer_node_alloc_arb u_main (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req_m),
        .req_class    (cls_m),
        .ack          (ack_m),
        .ack_node_idx (idx_m),
        .ack_deny     (deny_m),
        .clear_en     (clr_en_m),
        .clear_class  (clr_cls_m),
        .query_class  (q_cls_m),
        .query_count  (q_cnt_m),
        .busy         (busy_m)
`ifdef GAM_NODE_DENY_CNT_EN
        ,
        .deny_count   (dcnt_m)
`endif
    );

    memory_layer_node_alloc_arb #(.NODE_MAX(3)) u_sat (
        .clk          (clk),
        .rst_n        (rst_n),
        .req          (req_s),
        .req_class    (cls_s),
        .ack          (ack_s),
        .ack_node_idx (idx_s),
        .ack_deny     (deny_s),
        .clear_en     (clr_en_s),
        .clear_class  (clr_cls_s),
        .query_class  (q_cls_s),
        .query_count  (q_cnt_s),
        .busy         (busy_s)
`ifdef GAM_NODE_DENY_CNT_EN
        ,
        .deny_count   (dcnt_s)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         id;
        logic [2:0] cls;
        logic [7:0] exp_idx;
        logic       exp_deny;
        logic [7:0] exp_q;
    } vec_t;

    vec_t tbl [6];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end else begin
            n_pass++;
        end
    endtask

    // One request on instance sel (0 main, 1 sat); returns the ack seen and
    // how many falling edges after raising req it took to appear.
    task automatic txn(input int sel, input int id, input logic [2:0] cls,
                       output logic [3:0] a, output logic [7:0] idx,
                       output logic d, output int cyc);
        logic got;
        got = 1'b0;
        a   = 4'd0;
        idx = 8'd0;
        d   = 1'b0;
        cyc = 0;
        @(negedge clk);
        if (sel == 0) begin
            req_m[id] = 1'b1;
            cls_m[id*3 +: 3] = cls;
        end else begin
            req_s[id] = 1'b1;
            cls_s[id*3 +: 3] = cls;
        end
        for (int n = 0; n < 12 && !got; n++) begin
            @(negedge clk);
            cyc++;
            if (sel == 0 && ack_m != 4'd0) begin
                got = 1'b1; a = ack_m; idx = idx_m; d = deny_m;
            end else if (sel != 0 && ack_s != 4'd0) begin
                got = 1'b1; a = ack_s; idx = idx_s; d = deny_s;
            end
        end
        chk("ack_timeout", {31'd0, got}, 32'd1);
        @(posedge clk);
        #1;
        if (sel == 0) req_m[id] = 1'b0;
        else          req_s[id] = 1'b0;
    endtask

    logic [3:0] a;
    logic [7:0] idx;
    logic       d;
    int         cyc;
    logic       got;
    int         gap;

    initial begin
        n_pass = 0;
        n_total = 0;
        rst_n = 1'b0;
        req_m = 4'd0; cls_m = 12'd0; clr_en_m = 1'b0; clr_cls_m = 3'd0; q_cls_m = 3'd0;
        req_s = 4'd0; cls_s = 12'd0; clr_en_s = 1'b0; clr_cls_s = 3'd0; q_cls_s = 3'd0;

        tbl[0] = '{0, 3'd1, 8'd0, 1'b0, 8'd1};
        tbl[1] = '{1, 3'd1, 8'd1, 1'b0, 8'd2};
        tbl[2] = '{2, 3'd1, 8'd2, 1'b0, 8'd3};
        tbl[3] = '{3, 3'd1, 8'd3, 1'b1, 8'd3};
        tbl[4] = '{0, 3'd1, 8'd3, 1'b1, 8'd3};
        tbl[5] = '{2, 3'd4, 8'd0, 1'b0, 8'd1};

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_ack",  {28'd0, ack_m}, 32'd0);
        chk("rst_busy", {31'd0, busy_m}, 32'd0);
        chk("rst_idx",  {24'd0, idx_m}, 32'd0);
        chk("rst_deny", {31'd0, deny_m}, 32'd0);
        chk("rst_qcnt", {24'd0, q_cnt_m}, 32'd0);
        chk("rst_ack_sat", {28'd0, ack_s}, 32'd0);
`ifdef GAM_NODE_DENY_CNT_EN
        chk("rst_dcnt", {16'd0, dcnt_m}, 32'd0);
`endif
        rst_n = 1'b1;

        // Basic allocation with latency
        txn(0, 0, 3'd2, a, idx, d, cyc);
        chk("t1_ack", {28'd0, a}, 32'd1);
        chk("t1_lat", cyc, 32'd2);
        chk("t1_idx", {24'd0, idx}, 32'd0);
        chk("t1_deny", {31'd0, d}, 32'd0);
        q_cls_m = 3'd2;
        #1;
        chk("t1_qcnt", {24'd0, q_cnt_m}, 32'd1);

        // Saturation table on the NODE_MAX=3 instance
        for (int v = 0; v < 6; v++) begin
            txn(1, tbl[v].id, tbl[v].cls, a, idx, d, cyc);
            chk("sat_ack",  {28'd0, a}, 32'd1 << tbl[v].id);
            chk("sat_idx",  {24'd0, idx}, {24'd0, tbl[v].exp_idx});
            chk("sat_deny", {31'd0, d}, {31'd0, tbl[v].exp_deny});
            q_cls_s = tbl[v].cls;
            #1;
            chk("sat_qcnt", {24'd0, q_cnt_s}, {24'd0, tbl[v].exp_q});
        end
`ifdef GAM_NODE_DENY_CNT_EN
        chk("sat_dcnt", {16'd0, dcnt_s}, 32'd2);
`endif

        // Round robin from a fresh reset, all requesters on class 5
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        req_m = 4'hF;
        cls_m = {3'd5, 3'd5, 3'd5, 3'd5};
        for (int k = 0; k < 8; k++) begin
            got = 1'b0;
            gap = 0;
            for (int n = 0; n < 12 && !got; n++) begin
                @(negedge clk);
                gap++;
                if (ack_m != 4'd0) got = 1'b1;
            end
            chk("rr_timeout", {31'd0, got}, 32'd1);
            chk("rr_ack",  {28'd0, ack_m}, 32'd1 << (k % 4));
            chk("rr_idx",  {24'd0, idx_m}, k);
            chk("rr_deny", {31'd0, deny_m}, 32'd0);
            chk("rr_gap",  gap, (k == 0) ? 32'd2 : 32'd3);
        end
        @(posedge clk);
        #1;
        req_m = 4'd0;
        q_cls_m = 3'd5;
        @(negedge clk);
        chk("rr_qcnt", {24'd0, q_cnt_m}, 32'd8);

        // Clear pulsed while busy is deferred to the next idle cycle
        txn(0, 0, 3'd1, a, idx, d, cyc);
        chk("clr_pre0", {24'd0, idx}, 32'd0);
        txn(0, 3, 3'd1, a, idx, d, cyc);
        chk("clr_pre1", {24'd0, idx}, 32'd1);
        q_cls_m = 3'd1;
        @(negedge clk);
        req_m[1] = 1'b1;
        cls_m[5:3] = 3'd1;
        @(negedge clk);
        chk("clr_busy", {31'd0, busy_m}, 32'd1);
        clr_en_m = 1'b1;
        clr_cls_m = 3'd1;
        @(negedge clk);
        clr_en_m = 1'b0;
        chk("clr_ack", {28'd0, ack_m}, 32'd2);
        chk("clr_idx", {24'd0, idx_m}, 32'd2);
        chk("clr_q_upd", {24'd0, q_cnt_m}, 32'd3);
        @(posedge clk);
        #1;
        req_m[1] = 1'b0;
        @(negedge clk);
        chk("clr_q_wait", {24'd0, q_cnt_m}, 32'd3);
        @(negedge clk);
        chk("clr_q_done", {24'd0, q_cnt_m}, 32'd0);
        chk("clr_idle", {31'd0, busy_m}, 32'd0);
        txn(0, 1, 3'd1, a, idx, d, cyc);
        chk("clr_post_idx", {24'd0, idx}, 32'd0);
        chk("clr_post_lat", cyc, 32'd2);

        // Reset asserted while in UPDATE
        @(negedge clk);
        req_m[0] = 1'b1;
        cls_m[2:0] = 3'd5;
        q_cls_m = 3'd5;
        @(negedge clk);
        chk("rmid_busy", {31'd0, busy_m}, 32'd1);
        rst_n = 1'b0;
        #1;
        chk("rmid_busy0", {31'd0, busy_m}, 32'd0);
        chk("rmid_ack0",  {28'd0, ack_m}, 32'd0);
        chk("rmid_q5",    {24'd0, q_cnt_m}, 32'd0);
        q_cls_m = 3'd1;
        #1;
        chk("rmid_q1",    {24'd0, q_cnt_m}, 32'd0);
        req_m[0] = 1'b0;
        @(negedge clk);
        chk("rmid_noack", {28'd0, ack_m}, 32'd0);
        rst_n = 1'b1;
        txn(0, 2, 3'd3, a, idx, d, cyc);
        chk("rmid_ack2", {28'd0, a}, 32'd4);
        chk("rmid_idx",  {24'd0, idx}, 32'd0);
        chk("rmid_lat",  cyc, 32'd2);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
